// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//   clk, rst                  clock, synchronous active-high reset
//   start_i, annul_i          request pulse / pipeline flush
//   op_i                      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i, divisor_i     rs1 / rs2 values, sampled at accept
//   w_addr_i                  destination tag, sampled at accept
//   ready_o, busy_o, done_o   idle / computing / one-cycle result pulse
//   result_o, w_addr_o        last completed result and its tag
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero, signed overflow and
// |dividend| < |divisor| bypass the iteration and finish in two cycles.
module div_unit #(
    parameter int XLEN   = 32,
    parameter int ITER_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            annul_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      w_addr_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      w_addr_o
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    state_t state;
    logic [XLEN-1:0] q, rem, dvs, dnd;
    logic [ITER_W-1:0] cnt;
    logic [4:0] tag;
    logic is_rem, neg_q, neg_r, div0, ovf;
    logic accept, sdiv, dnd_neg, dvs_neg, a_div0, a_ovf, fast, ge;
    logic [XLEN-1:0] dnd_mag, dvs_mag, sub, q_fix, r_fix;
    logic [XLEN:0] sh;
    always_comb begin
        accept  = state == IDLE && start_i && !annul_i;
        sdiv    = ~op_i[0];
        dnd_neg = sdiv & dividend_i[XLEN-1];
        dvs_neg = sdiv & divisor_i[XLEN-1];
        dnd_mag = dnd_neg ? -dividend_i : dividend_i;
        dvs_mag = dvs_neg ? -divisor_i : divisor_i;
        a_div0  = divisor_i == '0;
        a_ovf   = sdiv && dividend_i == MIN_NEG && divisor_i == '1;
`ifdef DIV_FAST_SPECIAL_EN
        fast    = a_div0 || a_ovf || dnd_mag < dvs_mag;
`else
        fast    = 1'b0;
`endif
        // partial remainder can reach 33 bits after the shift; the low
        // 32 bits of the difference are exact whenever the subtract succeeds
        sh      = {rem, q[XLEN-1]};
        ge      = sh >= {1'b0, dvs};
        sub     = sh[XLEN-1:0] - dvs;
        q_fix   = div0 ? '1 : ovf ? MIN_NEG : neg_q ? -q : q;
        r_fix   = div0 ? dnd : ovf ? '0 : neg_r ? -rem : rem;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            w_addr_o <= '0;
            cnt      <= '0;
            q        <= '0;
            rem      <= '0;
            dvs      <= '0;
            dnd      <= '0;
            tag      <= '0;
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state != IDLE && annul_i) begin
                state   <= IDLE;
                ready_o <= 1'b1;
                busy_o  <= 1'b0;
            end else if (accept) begin
                // the fast path preloads rem/q so FIX sees quotient 0, remainder dividend
                state   <= fast ? FIX : CALC;
                ready_o <= 1'b0;
                busy_o  <= 1'b1;
                cnt     <= '0;
                q       <= fast ? '0 : dnd_mag;
                rem     <= fast ? dnd_mag : '0;
                dvs     <= dvs_mag;
                dnd     <= dividend_i;
                tag     <= w_addr_i;
                is_rem  <= op_i[1];
                neg_q   <= dnd_neg ^ dvs_neg;
                neg_r   <= dnd_neg;
                div0    <= a_div0;
                ovf     <= a_ovf;
            end else if (state == CALC) begin
                rem   <= ge ? sub : sh[XLEN-1:0];
                q     <= {q[XLEN-2:0], ge};
                cnt   <= cnt + ITER_W'(1);
                state <= cnt == ITER_W'(XLEN-1) ? FIX : CALC;
            end else if (state == FIX) begin
                state    <= IDLE;
                ready_o  <= 1'b1;
                busy_o   <= 1'b0;
                done_o   <= 1'b1;
                result_o <= is_rem ? r_fix : q_fix;
                w_addr_o <= tag;
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
    logic clk = 0, rst = 1, start = 0, annul = 0;
    logic [1:0] op = 0;
    logic [31:0] a = 0, b = 0, result;
    logic [4:0] tag = 0, w_addr;
    logic ready, busy, done;
    int checks = 0, failures = 0;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 33;
`endif
    div_unit dut (
        .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .op_i(op),
        .dividend_i(a), .divisor_i(b), .w_addr_i(tag), .ready_o(ready),
        .busy_o(busy), .done_o(done), .result_o(result), .w_addr_o(w_addr)
    );
    always #5 clk = ~clk;

    // drive a request; returns #1 after the accept edge (edge 0)
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
        op = o; a = x; b = y; tag = t; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    // counts edges until done is seen #1 after an edge; -1 if bound expires
    task automatic wait_done(output int n);
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (done) return;
            if (n > 100) begin n = -1; return; end
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk); #1;
        checks++; if ({ready, busy, done} !== 3'b100) begin failures++; $display("FAIL reset_flags got=%b exp=100", {ready, busy, done}); end
        checks++; if (result !== 0 || w_addr !== 0) begin failures++; $display("FAIL reset_result got=%h/%0d exp=0/0", result, w_addr); end
        rst = 0;
    endtask

    task automatic test_basic;
        int n;
        issue(2'b01, 100, 7, 5);
        checks++; if (busy !== 1 || ready !== 0) begin failures++; $display("FAIL basic_busy_e0 got=%b%b exp=10", busy, ready); end
        repeat (32) @(posedge clk); #1;
        checks++; if (busy !== 1 || done !== 0) begin failures++; $display("FAIL basic_busy_e32 got=%b%b exp=10", busy, done); end
        @(posedge clk); #1;
        checks++; if (done !== 1 || ready !== 1 || busy !== 0) begin failures++; $display("FAIL basic_done_e33 got=%b%b%b exp=110", done, ready, busy); end
        checks++; if (result !== 32'h0000000E || w_addr !== 5) begin failures++; $display("FAIL basic_result got=%h/%0d exp=0000000e/5", result, w_addr); end
        @(posedge clk); #1;
        checks++; if (done !== 0 || result !== 32'h0000000E) begin failures++; $display("FAIL basic_pulse got=%b/%h exp=0/0000000e", done, result); end
        n = 0;
    endtask

    task automatic test_back_to_back;
        int n;
        issue(2'b10, 32'hFFFFFFF9, 2, 7);
        wait_done(n);
        checks++; if (n !== 33 || result !== 32'hFFFFFFFF || w_addr !== 7) begin failures++; $display("FAIL b2b_rem got=%0d/%h/%0d exp=33/ffffffff/7", n, result, w_addr); end
        issue(2'b00, 32'hFFFFFFF9, 2, 8);
        wait_done(n);
        checks++; if (n !== 33 || result !== 32'hFFFFFFFD || w_addr !== 8) begin failures++; $display("FAIL b2b_div got=%0d/%h/%0d exp=33/fffffffd/8", n, result, w_addr); end
    endtask

    task automatic test_special;
        int n;
        logic [1:0]  ops [4] = '{2'b00, 2'b11, 2'b00, 2'b10};
        logic [31:0] xs  [4] = '{1234, 1234, 32'h80000000, 32'h80000000};
        logic [31:0] ys  [4] = '{0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] es  [4] = '{32'hFFFFFFFF, 32'h000004D2, 32'h80000000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], xs[i], ys[i], 5'(10 + i));
            wait_done(n);
            checks++; if (n !== FAST_LAT || result !== es[i] || w_addr !== 5'(10 + i)) begin failures++; $display("FAIL special_%0d got=%0d/%h/%0d exp=%0d/%h/%0d", i, n, result, w_addr, FAST_LAT, es[i], 10 + i); end
        end
        issue(2'b10, 32'hFFFFFF9C, 0, 14);
        wait_done(n);
        checks++; if (result !== 32'hFFFFFF9C) begin failures++; $display("FAIL special_rem0_neg got=%h exp=ffffff9c", result); end
    endtask

    task automatic test_fast_small;
        int n;
        issue(2'b01, 3, 10, 3);
        wait_done(n);
        checks++; if (n !== FAST_LAT || result !== 0) begin failures++; $display("FAIL small_divu got=%0d/%h exp=%0d/0", n, result, FAST_LAT); end
        issue(2'b10, 32'hFFFFFFFD, 10, 4);
        wait_done(n);
        checks++; if (n !== FAST_LAT || result !== 32'hFFFFFFFD) begin failures++; $display("FAIL small_rem got=%0d/%h exp=%0d/fffffffd", n, result, FAST_LAT); end
    endtask

    task automatic test_annul;
        logic [31:0] prior;
        logic [4:0] ptag;
        int seen;
        prior = result; ptag = w_addr; seen = 0;
        issue(2'b01, 50, 5, 2);
        repeat (9) @(posedge clk); #1;
        annul = 1;
        @(posedge clk); #1;
        annul = 0;
        checks++; if (ready !== 1 || busy !== 0 || done !== 0) begin failures++; $display("FAIL annul_state got=%b%b%b exp=100", ready, busy, done); end
        checks++; if (result !== prior || w_addr !== ptag) begin failures++; $display("FAIL annul_hold got=%h/%0d exp=%h/%0d", result, w_addr, prior, ptag); end
        start = 1; annul = 1;
        @(posedge clk); #1;
        start = 0; annul = 0;
        checks++; if (ready !== 1 || busy !== 0) begin failures++; $display("FAIL annul_start got=%b%b exp=10", ready, busy); end
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        checks++; if (seen !== 0 || result !== prior) begin failures++; $display("FAIL annul_nodone got=%0d/%h exp=0/%h", seen, result, prior); end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        issue(2'b01, 100, 7, 6);
        repeat (19) @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++; if ({ready, busy, done} !== 3'b100 || result !== 0 || w_addr !== 0) begin failures++; $display("FAIL rst_mid got=%b/%h/%0d exp=100/0/0", {ready, busy, done}, result, w_addr); end
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_nodone got=%0d exp=0", seen); end
    endtask

    task automatic test_start_mid;
        int n;
        issue(2'b01, 1000, 3, 9);
        repeat (4) @(posedge clk); #1;
        op = 2'b00; a = 77; b = 11; tag = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        wait_done(n);
        checks++; if (n + 5 !== 33 || result !== 333 || w_addr !== 9) begin failures++; $display("FAIL start_mid got=%0d/%h/%0d exp=33/0000014d/9", n + 5, result, w_addr); end
        @(posedge clk); #1;
        checks++; if (ready !== 1 || busy !== 0) begin failures++; $display("FAIL start_mid_idle got=%b%b exp=10", ready, busy); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_special;
        test_fast_small;
        test_annul;
        test_reset_mid;
        test_start_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider serving the EX stage for RV32M DIV/DIVU/REM/REMU.
- EX is the initiator: it pulses a start, holds its stall request while the divider is busy, and takes the result on the done pulse.
- The divider carries the destination register address alongside the operation so EX can form its write-back tuple.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- ITER_W, 6, iteration counter width; must satisfy 2^ITER_W > XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  request; accepted only when ready_o=1 and annul_i=0
- annul_i  in  1  pipeline flush; aborts an in-flight operation
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept
- dividend_i  in  XLEN  rs1 value; sampled at accept
- divisor_i  in  XLEN  rs2 value; sampled at accept
- w_addr_i  in  5  destination register tag; sampled at accept
- ready_o  out  1  high in IDLE
- busy_o  out  1  high in CALC and FIX; EX ORs this into stall_req_o
- done_o  out  1  one-cycle result-valid pulse
- result_o  out  XLEN  quotient or remainder; held until the next accept
- w_addr_o  out  5  tag of the result currently on result_o

Behaviour:
- Reset (rst=1 at an edge, including mid-operation): state=IDLE, ready_o=1, busy_o=0, done_o=0, result_o=0, w_addr_o=0, counter=0. Any in-flight operation is discarded.
- States and transitions:
  - IDLE: on accept go to CALC. Accept latches op, tag, sign flags, operand magnitudes (absolute values for DIV/REM, raw values for DIVU/REMU), clears the partial remainder, and sets counter=0.
  - CALC: each cycle do remainder={rem[30:0],q[31]}; trial subtract of the divisor magnitude; if non-negative keep the difference and shift in a quotient bit of 1, else shift in 0. Increment counter. After 32 iterations (counter==31 at the edge) go to FIX.
  - FIX: apply the result rules below, register result_o and w_addr_o, pulse done_o, go to IDLE.
- Latency: with an accept at edge N, done_o is high during exactly the cycle after edge N+33, and ready_o is high in that same cycle.
- Back-to-back: a start_i in the done cycle is accepted, giving a 34-cycle issue interval.
- Result rules, in priority order:
  1. Divisor=0: quotient=0xFFFFFFFF; remainder=dividend, unmodified.
  2. DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient=0x80000000, remainder=0.
  3. Otherwise, signed ops negate the quotient if the operand signs differ, and negate the remainder if the dividend was negative.
  - All arithmetic is modulo 2^32; no exceptions are raised.
- Handshake rules:
  - start_i while busy_o=1 is ignored; state and result are unaffected.
  - annul_i=1 in CALC or FIX: next state is IDLE, no done_o pulse, result_o and w_addr_o keep their previous values.
  - annul_i and start_i together in IDLE: no accept.
  - annul_i in IDLE: no effect.
- done_o is never asserted for more than one cycle.
- Outside the done cycle, result_o/w_addr_o are stable values from the last completed operation.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- Defined: at accept, the block detects divisor=0, signed overflow (rule 2), or unsigned |dividend| < |divisor|. In these cases it skips CALC and goes directly to FIX, so done_o is high in the cycle after edge N+1. For the |dividend| < |divisor| case, quotient=0 and remainder=dividend.
- Not defined: every operation takes the full 34-cycle latency. Special-case results are still per the rules above.

Test Plan:
- DIVU 100/7, tag 5, accept at edge 0 -> done_o only in the cycle after edge 33; result_o=14 (0x0000000E); w_addr_o=5; busy_o high from edge 0 through edge 33.
- REM -7 (0xFFFFFFF9) by 2, then back-to-back DIV -7/2 started in the done cycle -> first result 0xFFFFFFFF (-1), second result 0xFFFFFFFD (-3), 34 cycles apart.
- DIV 1234/0 -> 0xFFFFFFFF; REMU 1234/0 -> 0x000004D2; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- DIVU 50/5 accepted, annul_i at cycle 10 -> no done_o, ready_o=1 next cycle, result_o keeps its prior value. Then start_i with annul_i together -> not accepted.
- rst asserted at cycle 20 of an operation -> next cycle all outputs are at reset values and no done_o follows. A start_i pulsed mid-CALC -> ignored, original result correct.
- With DIV_FAST_SPECIAL_EN defined, DIVU 3/10 -> done_o in the cycle after edge 1, quotient 0. Without it -> same result in the cycle after edge 33.
